vc_rotation_packer: RTL
=======================

// Module: vc_rotation_packer
// PURPOSE
//  Transmit-side packer for the vector rotation datapath. Accepts beats of 1..NUM_ELEMENTS valid
//  elements, forward-rotates each beat by the running fill pointer, and emits densely packed
//  NUM_ELEMENTS-wide vectors. The consumer recovers beat boundaries with a back-rotation by the
//  same pointer. Sits between variable-rate element producers and fixed-width vector consumers.
// PARAMETERS
//  DATA_WIDTH    32                         bits per element
//  NUM_ELEMENTS  16                         elements per vector; power of 2, >=2
//  ADDR_WIDTH    $clog2(NUM_ELEMENTS)       derived, not set manually; fill pointer width
//  CNT_WIDTH     $clog2(NUM_ELEMENTS+1)     derived, not set manually; element count width
// PORTS
//  clk        in   1                        clock, rising edge
//  rst_n      in   1                        asynchronous active-low reset
//  in_valid   in   1                        input beat valid
//  in_ready   out  1                        input beat accepted when in_valid & in_ready
//  in_data    in   DATA_WIDTH*NUM_ELEMENTS  element j at [(j+1)*DATA_WIDTH-1 : j*DATA_WIDTH]
//  in_count   in   CNT_WIDTH                valid elements, occupying lanes 0..in_count-1
//  in_last    in   1                        end of packet: flush partial vector after this beat
//  out_valid  out  1                        output vector valid
//  out_ready  in   1                        output vector consumed when out_valid & out_ready
//  out_data   out  DATA_WIDTH*NUM_ELEMENTS  packed vector; unused lanes are zero
//  out_count  out  CNT_WIDTH                valid lanes in out_data (NUM_ELEMENTS, or fewer on flush)
//  out_last   out  1                        final vector of a packet
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_count=0, out_last=0, ptr=0, staging=0, state=ACCUM.
//    Reset mid-packet discards staged elements.
//  - Effective count c = min(in_count, NUM_ELEMENTS). Input element j maps to lane (ptr+j)%NUM_ELEMENTS.
//  - in_ready = (state==ACCUM) && (!out_valid || out_ready), combinational. Output is one register, no skid.
//  - On accept with ptr+c < NUM_ELEMENTS: write lanes ptr..ptr+c-1 into staging, ptr += c.
//    If in_last and the new ptr != 0: emit staging as partial vector (out_count=ptr, out_last=1);
//    clear staging; ptr=0.
//  - On accept with ptr+c >= NUM_ELEMENTS: the output register loads staging lanes 0..ptr-1 plus the
//    rotated input in lanes ptr..N-1 (out_count=N). Leftover r = ptr+c-N input elements go to staging
//    lanes 0..r-1; ptr = r.
//    in_last & r==0: out_last=1.
//    in_last & r!=0: out_last=0, then go to FLUSH.
//  - FLUSH: in_ready=0. When the output register is free, emit the leftover as a partial vector
//    (out_count=r, out_last=1), clear staging, ptr=0, return to ACCUM.
//  - c==0: no lanes written. If in_last and ptr!=0, flush; if ptr==0, nothing is emitted.
//  - Latency: out_valid asserts 1 cycle after the accepting edge. out_* hold stable while
//    out_valid & !out_ready.
//  - ptr arithmetic is modulo NUM_ELEMENTS (ADDR_WIDTH bits); the sum ptr+c uses CNT_WIDTH+1 bits.
// CONFIGURATION
//  VC_ROT_PACK_COUNT_CHECK_EN
//   defined:   adds output err_overcount (1 bit, reset 0). It is set sticky until reset when an
//              accepted beat has in_count > NUM_ELEMENTS. Data is still clamped.
//   undefined: port absent; silent clamp only.
// TESTING (N=4, DATA_WIDTH=8 unless noted)
//  1. Beats cnt3{A,B,C}, cnt3{D,E,F}, last cnt2{G,H} -> {A,B,C,D} cnt4;
//     then {E,F,G,H} cnt4 last=1; ptr=0.
//  2. ptr=3 (staged X,Y,Z), beat cnt3{P,Q,R} last -> {X,Y,Z,P} cnt4 last=0; in_ready=0 one cycle;
//     then {Q,R,0,0} cnt2 last=1.
//  3. out_ready=0 for 5 cycles with a full vector pending -> in_ready=0, out_data stable;
//     release -> 1 transfer, no loss or duplication.
//  4. Beat cnt0 last with ptr=0 -> no output; cnt0 last with ptr=2 -> partial cnt2 last=1.
//  5. rst_n low mid-packet with ptr=2 -> outputs zero asynchronously; next packet starts at lane 0.
//  6. With VC_ROT_PACK_COUNT_CHECK_EN: in_count=7 -> treated as 4, err_overcount=1 until reset;
//     N=16 random counts scoreboarded against a reference queue.

Source files
------------

// File: rtl/vc_rotation_packer.sv
// Transmit-side rotation packer: folds variable-count beats into dense NUM_ELEMENTS-wide vectors.
// Optional macro VC_ROT_PACK_COUNT_CHECK_EN adds the sticky err_overcount output.
module vc_rotation_packer #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_ELEMENTS = 16,
    localparam int ADDR_WIDTH  = $clog2(NUM_ELEMENTS),
    localparam int CNT_WIDTH   = $clog2(NUM_ELEMENTS + 1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH*NUM_ELEMENTS-1:0] in_data,
    input  logic [CNT_WIDTH-1:0]               in_count,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH*NUM_ELEMENTS-1:0] out_data,
    output logic [CNT_WIDTH-1:0]               out_count,
    output logic                               out_last
`ifdef VC_ROT_PACK_COUNT_CHECK_EN
    ,
    output logic                               err_overcount
`endif
);

    typedef enum logic {ACCUM, FLUSH} state_t;

    state_t                                   state, state_next;
    logic [ADDR_WIDTH-1:0]                    ptr, ptr_next;
    logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]  staging, staging_next;
    logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]  in_vec, rot, merged, leftover, out_vec_next;
    logic [NUM_ELEMENTS-1:0][ADDR_WIDTH-1:0]  lane_off;
    logic [CNT_WIDTH-1:0]                     eff_count, out_count_next;
    logic [CNT_WIDTH:0]                       fill_sum;
    logic                                     accept, out_free, load_out, out_last_next;

    assign in_vec   = in_data;
    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == ACCUM) && out_free;
    assign accept   = in_valid && in_ready;

    assign eff_count = (in_count > CNT_WIDTH'(NUM_ELEMENTS)) ? CNT_WIDTH'(NUM_ELEMENTS) : in_count;
    assign fill_sum  = {1'b0, CNT_WIDTH'(ptr)} + {1'b0, eff_count};

    // Lane l holds input element (l - ptr) mod N when that element is within the beat's count.
    // Lanes below ptr keep staged data; in the wrap case those same lanes carry the leftover.
    always_comb begin
        rot      = '0;
        merged   = '0;
        leftover = '0;
        lane_off = '0;
        for (int l = 0; l < NUM_ELEMENTS; l++) begin
            lane_off[l] = ADDR_WIDTH'(l) - ptr;
            if ({1'b0, lane_off[l]} < eff_count)
                rot[l] = in_vec[lane_off[l]];
            if (ADDR_WIDTH'(l) < ptr) begin
                merged[l]   = staging[l];
                leftover[l] = rot[l];
            end else begin
                merged[l]   = rot[l];
            end
        end
    end

    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        staging_next   = staging;
        load_out       = 1'b0;
        out_vec_next   = merged;
        out_count_next = '0;
        out_last_next  = 1'b0;
        case (state)
            ACCUM: begin
                if (accept) begin
                    if (fill_sum < (CNT_WIDTH+1)'(NUM_ELEMENTS)) begin
                        if (in_last && (fill_sum != '0)) begin
                            load_out       = 1'b1;
                            out_count_next = fill_sum[CNT_WIDTH-1:0];
                            out_last_next  = 1'b1;
                            staging_next   = '0;
                            ptr_next       = '0;
                        end else begin
                            staging_next   = merged;
                            ptr_next       = fill_sum[ADDR_WIDTH-1:0];
                        end
                    end else begin
                        // sum is below 2N, so the low bits are the leftover count
                        load_out       = 1'b1;
                        out_count_next = CNT_WIDTH'(NUM_ELEMENTS);
                        staging_next   = leftover;
                        ptr_next       = fill_sum[ADDR_WIDTH-1:0];
                        if (in_last) begin
                            if (fill_sum[ADDR_WIDTH-1:0] == '0)
                                out_last_next = 1'b1;
                            else
                                state_next    = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    load_out       = 1'b1;
                    out_vec_next   = staging;
                    out_count_next = CNT_WIDTH'(ptr);
                    out_last_next  = 1'b1;
                    staging_next   = '0;
                    ptr_next       = '0;
                    state_next     = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            ptr       <= '0;
            staging   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            staging <= staging_next;
            if (load_out) begin
                out_valid <= 1'b1;
                out_data  <= out_vec_next;
                out_count <= out_count_next;
                out_last  <= out_last_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef VC_ROT_PACK_COUNT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_overcount <= 1'b0;
        else if (accept && (in_count > CNT_WIDTH'(NUM_ELEMENTS)))
            err_overcount <= 1'b1;
    end
`endif

endmodule
